wrd_decision: RTL

- Sits directly downstream of the word-recognition MAC stage. It consumes one packed vector of per-class signed scores per audio frame.
- A serial argmax picks the winning class and reports the class index and its score on a streaming output.
- A consecutive-frame debounce with cooldown turns repeated confident wake-class wins into a single-cycle wake pulse.

---
 rtl/wrd_pkg.sv | 22 ++
 rtl/wrd_debounce.sv | 59 +++++
 rtl/wrd_decision.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wrd_pkg.sv
// Shared types and constants for the wake-word decision block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wrd_pkg;

    // Width of the hit and cooldown counters; holds values 0..15.
    localparam int CNT_W = 4;

    // Decision FSM: wait for a frame, scan classes serially, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Class index width. A single bit is kept even for very small class counts
    // so that the index port never collapses to zero width.
    function automatic int cls_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrd_debounce.sv
// Consecutive-frame debounce with cooldown: turns repeated qualifying frames into one wake pulse.
// Latency: wake_o is registered, high for one cycle directly after the update strobe.
// Backpressure: none; one update per accepted frame is supplied by the parent FSM.
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   upd_i        : one-cycle strobe, one per completed frame decision
//   qual_i       : frame qualifies (winner is the wake class and above threshold)
//   wake_o       : one-cycle wake pulse
module wrd_debounce
    import wrd_pkg::*;
#(
    parameter int HOLD_FRAMES     = 2,
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic upd_i,
    input  logic qual_i,
    output logic wake_o
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] COOL_C = CNT_W'(COOLDOWN_FRAMES);

    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] cool_cnt;
    logic [CNT_W-1:0] hit_inc;

    assign hit_inc = hit_cnt + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt  <= '0;
            cool_cnt <= '0;
            wake_o   <= 1'b0;
        end else begin
            // Pulse lasts only the cycle following the strobe.
            wake_o <= 1'b0;
            if (upd_i) begin
                if (cool_cnt != '0) begin
                    // Cooldown swallows frames entirely, qualifying or not, and
                    // the streak must be rebuilt from scratch afterwards.
                    cool_cnt <= cool_cnt - CNT_W'(1);
                    hit_cnt  <= '0;
                end else if (qual_i && (hit_inc == HOLD_C)) begin
                    wake_o   <= 1'b1;
                    hit_cnt  <= '0;
                    cool_cnt <= COOL_C;
                end else if (qual_i) begin
                    hit_cnt <= hit_inc;
                end else begin
                    hit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/wrd_decision.sv
// Per-frame argmax over class scores plus debounced wake detection.
// Latency: valid_o is seen on the NUM_CLASSES-th clock edge counting the accepting edge; one frame per NUM_CLASSES+1 cycles.
// Backpressure: ready_o only in IDLE; result held in OUT until ready_i; valid_i ignored while busy.
//
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   data_i           : packed signed scores, class k at [(k+1)*O_BW-1 : k*O_BW]
//   valid_i, last_i  : input beat valid and end-of-packet (last passes through)
//   ready_o          : block can accept a frame
//   class_o, score_o : winning class index and its signed score
//   valid_o, last_o  : result valid and registered last of the held frame
//   ready_i          : downstream accepts the result
//   wake_o           : one-cycle wake pulse, first OUT cycle only
module wrd_decision
    import wrd_pkg::*;
#(
    parameter int O_BW            = 24,
    parameter int NUM_CLASSES     = 3,
    parameter int WAKE_CLASS      = 1,
    parameter int THRESH          = 1000,
    parameter int HOLD_FRAMES     = 2,
    parameter int COOLDOWN_FRAMES = 3,
    localparam int CLS_W          = cls_w(NUM_CLASSES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CLASSES*O_BW-1:0]   data_i,
    input  logic                          valid_i,
    input  logic                          last_i,
    output logic                          ready_o,
    output logic [CLS_W-1:0]              class_o,
    output logic signed [O_BW-1:0]        score_o,
    output logic                          valid_o,
    output logic                          last_o,
    input  logic                          ready_i,
    output logic                          wake_o
);

    // Threshold sign-extended to the score width so the compare is a true
    // O_BW-bit signed compare.
    localparam logic signed [O_BW-1:0] THRESH_S = O_BW'(THRESH);
    localparam logic [CLS_W-1:0]       LAST_K   = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CLS_W-1:0]       WAKE_IDX = CLS_W'(WAKE_CLASS);

    state_t                        state;
    logic [NUM_CLASSES*O_BW-1:0]   data_r;
    logic [CLS_W-1:0]              scan_k;
    logic [CLS_W-1:0]              best_idx;
    logic signed [O_BW-1:0]        best_score;
    logic                          ready_q;
    logic                          valid_q;
    logic                          last_q;

    logic signed [O_BW-1:0]        cand;
    logic                          take;
    logic [CLS_W-1:0]              nxt_idx;
    logic signed [O_BW-1:0]        nxt_score;
    logic                          qual;
    logic                          upd;

    // Candidate score for the class under test. Written as an explicit mux so
    // no part-select can ever reach past the packed vector.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_k == CLS_W'(i)) begin
                cand = data_r[i*O_BW +: O_BW];
            end
        end
    end

    // Strict greater-than: on a tie the earlier (lower) index is kept.
    always_comb begin
        take      = (cand > best_score);
        nxt_idx   = take ? scan_k : best_idx;
        nxt_score = take ? cand   : best_score;
    end

    // Decision inputs are taken from the final best, i.e. the same values that
    // land in best_idx/best_score on the SCAN->OUT edge.
    assign upd  = (state == SCAN) && (scan_k == LAST_K);
    assign qual = (nxt_idx == WAKE_IDX) && (nxt_score > THRESH_S);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            data_r     <= '0;
            scan_k     <= '0;
            best_idx   <= '0;
            best_score <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ready_q comes up one cycle after reset release; accept
                    // only once it is visible to upstream.
                    if (valid_i && ready_q) begin
                        data_r     <= data_i;
                        last_q     <= last_i;
                        best_idx   <= '0;
                        best_score <= data_i[O_BW-1:0];
                        scan_k     <= CLS_W'(1);
                        ready_q    <= 1'b0;
                        state      <= SCAN;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                SCAN: begin
                    best_idx   <= nxt_idx;
                    best_score <= nxt_score;
                    if (scan_k == LAST_K) begin
                        valid_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        scan_k <= scan_k + CLS_W'(1);
                    end
                end

                OUT: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign class_o = best_idx;
    assign score_o = best_score;

    wrd_debounce #(
        .HOLD_FRAMES     (HOLD_FRAMES),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_debounce (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .upd_i  (upd),
        .qual_i (qual),
        .wake_o (wake_o)
    );

endmodule
